fixed_leaky_relu_pipe: RTL and testbench

// Pipelined, backpressure-correct fixed-point LeakyReLU for the activation library.
// - Applies a runtime-programmable negative slope to a vector of lanes.
// - Rescales from the input fixed-point format to the output format, with rounding and saturation.
// - Sits between streaming compute blocks on the standard valid/ready data_in_0/data_out_0 interface.

---
 rtl/fixed_leaky_relu_pipe.sv | 179 +++++++++++++++++
 tb/tb_fixed_leaky_relu_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_leaky_relu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fixed_leaky_relu_pipe
// Brief   : Two-stage valid/ready pipelined fixed-point LeakyReLU over N
//           lanes. It applies a runtime-programmable negative slope and
//           rescales to the output format with round-half-up and saturation.
// Options : FIXED_LEAKY_RELU_SAT_COUNT_EN - adds the sat_count output, a
//           sticky count of output beats with at least one saturated lane.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_leaky_relu_pipe #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int SLOPE_WIDTH                 = 8,
  parameter logic [SLOPE_WIDTH-1:0] SLOPE_RESET = 'h40
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                             data_in_0_valid,
  output logic                                             data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                             data_out_0_valid,
  input  logic                                             data_out_0_ready,
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
  output logic [15:0]                                      sat_count,
`endif
  input  logic [SLOPE_WIDTH-1:0]                           slope_in,
  input  logic                                             slope_load
);

  localparam int c_N      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int c_IN_W   = DATA_IN_0_PRECISION_0;
  localparam int c_IN_F   = DATA_IN_0_PRECISION_1;
  localparam int c_OUT_W  = DATA_OUT_0_PRECISION_0;
  localparam int c_OUT_F  = DATA_OUT_0_PRECISION_1;
  // Stage-1 product width; fraction is c_IN_F + SLOPE_WIDTH
  localparam int c_P_W    = c_IN_W + SLOPE_WIDTH + 1;
  // Fraction-bit difference between the product and the output format
  localparam int c_D      = c_IN_F + SLOPE_WIDTH - c_OUT_F;
  localparam int c_SHR    = (c_D > 0) ? c_D : 0;
  localparam int c_SHL    = (c_D < 0) ? -c_D : 0;
  localparam int c_SHR_M1 = (c_SHR > 0) ? c_SHR - 1 : 0;
  // One guard bit for the rounding add, plus room for any left shift,
  // and never narrower than the output plus a sign bit for the clamp compare
  localparam int c_EXT_A  = c_P_W + 1 + c_SHL;
  localparam int c_EXT_W  = (c_EXT_A > c_OUT_W + 1) ? c_EXT_A : c_OUT_W + 1;

  localparam logic [c_EXT_W-1:0] c_ONE = {{(c_EXT_W-1){1'b0}}, 1'b1};
  localparam logic signed [c_EXT_W-1:0] c_RND = (c_SHR > 0) ? (c_ONE << c_SHR_M1) : '0;
  localparam logic signed [c_EXT_W-1:0] c_MAX = {{(c_EXT_W-c_OUT_W+1){1'b0}}, {(c_OUT_W-1){1'b1}}};
  localparam logic signed [c_EXT_W-1:0] c_MIN = {{(c_EXT_W-c_OUT_W+1){1'b1}}, {(c_OUT_W-1){1'b0}}};
  localparam logic [c_OUT_W-1:0] c_SAT_HI = {1'b0, {(c_OUT_W-1){1'b1}}};
  localparam logic [c_OUT_W-1:0] c_SAT_LO = {1'b1, {(c_OUT_W-1){1'b0}}};

  logic                     r_s1_valid;
  logic [c_N*c_P_W-1:0]     r_s1_p;
  logic                     r_s2_valid;
  logic [c_N*c_OUT_W-1:0]   r_out;
  logic [SLOPE_WIDTH-1:0]   r_slope;

  logic                     w_s1_en;
  logic                     w_s2_en;
  logic [c_N*c_P_W-1:0]     w_s1_p;
  logic [c_N*c_OUT_W-1:0]   w_q_all;
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
  logic [c_N-1:0]           w_lane_sat;
`endif

  // Each stage may advance when it is empty or the stage after it advances
  assign w_s2_en          = !r_s2_valid || data_out_0_ready;
  assign w_s1_en          = !r_s1_valid || w_s2_en;
  assign data_in_0_ready  = w_s1_en;
  assign data_out_0_valid = r_s2_valid;
  assign data_out_0       = r_out;

  for (genvar l = 0; l < c_N; l++) begin : g_lane
    logic signed [c_IN_W-1:0]  w_x;
    logic signed [c_P_W-1:0]   w_x_ext;
    logic signed [c_P_W-1:0]   w_slope_ext;
    logic signed [c_P_W-1:0]   w_prod;
    logic signed [c_P_W-1:0]   w_pos;
    logic signed [c_P_W-1:0]   w_p2;
    logic signed [c_EXT_W-1:0] w_ext;
    logic signed [c_EXT_W-1:0] w_rnd;
    logic signed [c_EXT_W-1:0] w_scaled;
    logic                      w_hi;
    logic                      w_lo;

    // Stage 1: negative (and zero) inputs are scaled by the slope; positive
    // inputs pass through shifted into the same product format
    assign w_x         = data_in_0[l*c_IN_W +: c_IN_W];
    assign w_x_ext     = {{(c_P_W-c_IN_W){w_x[c_IN_W-1]}}, w_x};
    assign w_slope_ext = {{(c_P_W-SLOPE_WIDTH){1'b0}}, r_slope};
    assign w_prod      = w_x_ext * w_slope_ext;
    assign w_pos       = {w_x[c_IN_W-1], w_x, {SLOPE_WIDTH{1'b0}}};
    assign w_s1_p[l*c_P_W +: c_P_W] = (!w_x[c_IN_W-1] && (|w_x)) ? w_pos : w_prod;

    // Stage 2: round half up, align to the output fraction, then clamp
    assign w_p2     = r_s1_p[l*c_P_W +: c_P_W];
    assign w_ext    = {{(c_EXT_W-c_P_W){w_p2[c_P_W-1]}}, w_p2};
    assign w_rnd    = w_ext + c_RND;
    assign w_scaled = (w_rnd >>> c_SHR) <<< c_SHL;
    assign w_hi     = (w_scaled > c_MAX);
    assign w_lo     = (w_scaled < c_MIN);
    assign w_q_all[l*c_OUT_W +: c_OUT_W] = w_hi ? c_SAT_HI :
                                           w_lo ? c_SAT_LO :
                                           w_scaled[c_OUT_W-1:0];
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
    assign w_lane_sat[l] = w_hi | w_lo;
`endif
  end

  // Slope register; a beat accepted on the load edge still sees the old value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slope <= SLOPE_RESET;
    end else if (slope_load) begin
      r_slope <= slope_in;
    end
  end

  // Stage 1 register: capture the slope-scaled product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= data_in_0_valid;
      if (data_in_0_valid) begin
        r_s1_p <= w_s1_p;
      end
    end
  end

  // Stage 2 register: hold the rescaled result until downstream takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_q_all;
      end
    end
  end

`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
  logic        r_s2_sat;
  logic [15:0] r_sat_count;

  // Track whether the beat held in stage 2 had any saturated lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_sat <= 1'b0;
    end else if (w_s2_en && r_s1_valid) begin
      r_s2_sat <= |w_lane_sat;
    end
  end

  // Sticky count of delivered beats that saturated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_count <= 16'h0000;
    end else if (r_s2_valid && data_out_0_ready && r_s2_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'h0001;
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixed_leaky_relu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fixed_leaky_relu_pipe
// Brief   : Scoreboard bench. Two instances share all stimulus: one with the
//           default 8-bit output, and one with a 6-bit output so that the
//           saturation paths are reachable.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fixed_leaky_relu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in_0;
  logic       in_valid;
  logic       in_ready8, in_ready6;
  logic [7:0] d8;
  logic [5:0] d6;
  logic       v8, v6;
  logic       out_ready;
  logic [7:0] slope_in;
  logic       slope_load;
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
  logic [15:0] sat8, sat6;
`endif

  always #5 clk = ~clk;

  fixed_leaky_relu_pipe u_dut8 (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready8),
    .data_out_0(d8), .data_out_0_valid(v8), .data_out_0_ready(out_ready),
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
    .sat_count(sat8),
`endif
    .slope_in(slope_in), .slope_load(slope_load)
  );

  fixed_leaky_relu_pipe #(.DATA_OUT_0_PRECISION_0(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready6),
    .data_out_0(d6), .data_out_0_valid(v6), .data_out_0_ready(out_ready),
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
    .sat_count(sat6),
`endif
    .slope_in(slope_in), .slope_load(slope_load)
  );

  typedef struct {
    logic [7:0] e8;
    logic [5:0] e6;
    bit         sat;
    bit         lat;
    int         stamp;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_sat = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'd0, v8}, 32'd1);
        check("hold_data", {24'd0, d8}, {24'd0, hold_d8});
      end
      if (v8 && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got valid beat %0h expected none", d8);
        end else begin
          e = q.pop_front();
          check("out8", {24'd0, d8}, {24'd0, e.e8});
          check("out6", {25'd0, v6, d6}, {25'd0, 1'b1, e.e6});
          if (e.lat) check("latency", cyc, e.stamp + 2);
          if (e.sat) exp_sat++;
        end
      end
      hold    = v8 && !out_ready;
      hold_d8 = d8;
    end
  end

  // Present one beat (caller is at a negedge); returns at the negedge after acceptance
  task automatic send(input logic [7:0] d, input logic [7:0] e8, input logic [5:0] e6,
                      input bit sat, input bit lat, input bit ld, input logic [7:0] sv);
    exp_t e;
    data_in_0  = d;
    in_valid   = 1'b1;
    slope_load = ld;
    slope_in   = sv;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (in_ready8) begin
        e.e8 = e8; e.e6 = e6; e.sat = sat; e.lat = lat; e.stamp = cyc;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        slope_load = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no ready for %0h expected ready", d);
    slope_load = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  // Identity / slope / rounding vectors at slope 0.25.
  // 0xFA: -6*64 = -384, +128 = -256, >>>8 = -1 -> 0xFF (6-bit 0x3F).
  logic [7:0] p1_in  [8] = '{8'h20, 8'hF0, 8'h80, 8'h00, 8'hFF, 8'hFE, 8'hFA, 8'h40};
  logic [7:0] p1_e8  [8] = '{8'h20, 8'hFC, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h40};
  logic [5:0] p1_e6  [8] = '{6'h1F, 6'h3C, 6'h20, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h1F};
  bit         p1_sat [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
  // Backpressure burst at slope 0.25
  logic [7:0] bp_in  [6] = '{8'h10, 8'h20, 8'h30, 8'hF0, 8'hE0, 8'h70};
  logic [7:0] bp_e8  [6] = '{8'h10, 8'h20, 8'h30, 8'hFC, 8'hF8, 8'h70};
  logic [5:0] bp_e6  [6] = '{6'h10, 6'h1F, 6'h1F, 6'h3C, 6'h38, 6'h1F};
  bit         bp_sat [6] = '{0, 1, 1, 0, 0, 1};

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    data_in_0  = 8'h00;
    out_ready  = 1'b1;
    slope_in   = 8'h00;
    slope_load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, v8}, 32'd0);
    check("reset_data", {24'd0, d8}, 32'd0);
    check("reset_ready", {31'd0, in_ready8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back directed vectors with latency checks
    for (int i = 0; i < 8; i++) send(p1_in[i], p1_e8[i], p1_e6[i], p1_sat[i], 1'b1, 1'b0, 8'h00);
    in_valid = 1'b0;
    drain();

    // Slope load on the accept edge of A: A uses 0.25, B uses 0.5
    send(8'hF0, 8'hFC, 6'h3C, 1'b0, 1'b0, 1'b1, 8'h80);
    send(8'hF0, 8'hF8, 6'h38, 1'b0, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b0;
    drain();

    // Slope 0xFF: -128*255 = -32640, +128, >>>8 = -127 -> 0x81, 6-bit clamps to 0x20
    slope_in   = 8'hFF;
    slope_load = 1'b1;
    @(negedge clk);
    slope_load = 1'b0;
    send(8'h80, 8'h81, 6'h20, 1'b1, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b0;
    drain();
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
    check("sat_count6_pre", {16'd0, sat6}, exp_sat);
    check("sat_count8_pre", {16'd0, sat8}, 32'd0);
`endif

    // Reset with two beats in flight; neither may ever appear
    data_in_0 = 8'h10;
    in_valid  = 1'b1;
    #1;
    check("rst_pre_ready", {31'd0, in_ready8}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    data_in_0 = 8'h20;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_sat  = 0;
    #1;
    check("rst_async_valid", {31'd0, v8}, 32'd0);
    check("rst_async_data", {24'd0, d8}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_output", q.size(), 0);

    // Backpressure: ready low for five cycles starting two cycles in
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_in[i], bp_e8[i], bp_e6[i], bp_sat[i], 1'b0, 1'b0, 8'h00);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        #3;
        check("bp_in_ready_low", {31'd0, in_ready8}, 32'd0);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(negedge clk);
`ifdef FIXED_LEAKY_RELU_SAT_COUNT_EN
    check("sat_count6", {16'd0, sat6}, exp_sat);
    check("sat_count8", {16'd0, sat8}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
